// File: rtl/rr_arb_pkg.sv
// Shared types and limits for the round-robin arbiter.
package rr_arb_pkg;

  typedef enum logic {
    RR_IDLE  = 1'b0,
    RR_GRANT = 1'b1
  } rr_state_e;

  localparam int unsigned RR_CNT_W = 8;
  localparam int unsigned RR_N_MIN = 2;
  localparam int unsigned RR_N_MAX = 16;

endpackage

// File: rtl/rr_pick.sv
// Combinational pick of the first set request bit at or after ptr, wrapping modulo N_REQ.
module rr_pick
  import rr_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] onehot,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  logic [IDX_W-1:0] pos;

  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    pos    = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      pos = IDX_W'((32'(ptr) + k) % N_REQ);
      if (!found && req[pos]) begin
        found       = 1'b1;
        idx         = pos;
        onehot[pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with grant lock and zero-bubble handover.
// Optional forced handover after MAX_HOLD cycles when RR_ARB_TIMEOUT_EN is defined.
module rr_arbiter
  import rr_arb_pkg::*;
#(
  parameter int unsigned N_REQ    = 2,
  parameter int unsigned IDX_W    = $clog2(N_REQ),
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld
);

  if (N_REQ < RR_N_MIN || N_REQ > RR_N_MAX || MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_param
    $error("rr_arbiter: N_REQ or MAX_HOLD out of range");
  end

  rr_state_e        state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [N_REQ-1:0] gnt_d;
  logic [IDX_W-1:0] idx_d;
  logic [IDX_W-1:0] ptr_inc;

  logic [N_REQ-1:0] idle_oh, next_oh;
  logic [IDX_W-1:0] idle_idx, next_idx;
  logic             idle_found, next_found;
  logic             owner_rel;
  logic             force_ho;

  assign ptr_inc   = (gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
  assign owner_rel = ~req[gnt_idx];

  rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick_idle (
    .req    (req),
    .ptr    (ptr_q),
    .onehot (idle_oh),
    .idx    (idle_idx),
    .found  (idle_found)
  );

  // Owner masked out so a forced handover never re-picks the current owner.
  rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick_next (
    .req    (req & ~gnt),
    .ptr    (ptr_inc),
    .onehot (next_oh),
    .idx    (next_idx),
    .found  (next_found)
  );

`ifdef RR_ARB_TIMEOUT_EN
  logic [RR_CNT_W-1:0] cnt_q, cnt_d;

  // cnt_q counts completed grant cycles; the edge that would bring it to MAX_HOLD hands over.
  assign force_ho = (cnt_q >= RR_CNT_W'(MAX_HOLD - 1)) && next_found;

  always_comb begin
    cnt_d = '0;
    if (state_q == RR_GRANT && !owner_rel && !force_ho) begin
      cnt_d = (cnt_q < RR_CNT_W'(MAX_HOLD)) ? cnt_q + RR_CNT_W'(1) : cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  assign force_ho = 1'b0;
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt;
    idx_d   = gnt_idx;
    unique case (state_q)
      RR_IDLE: begin
        if (idle_found) begin
          gnt_d   = idle_oh;
          idx_d   = idle_idx;
          state_d = RR_GRANT;
        end
      end
      RR_GRANT: begin
        if (owner_rel || force_ho) begin
          ptr_d = ptr_inc;
          if (next_found) begin
            gnt_d = next_oh;
            idx_d = next_idx;
          end else begin
            gnt_d   = '0;
            idx_d   = '0;
            state_d = RR_IDLE;
          end
        end
      end
      default: begin
        gnt_d   = '0;
        idx_d   = '0;
        state_d = RR_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= RR_IDLE;
      ptr_q   <= '0;
      gnt     <= '0;
      gnt_idx <= '0;
      gnt_vld <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt     <= gnt_d;
      gnt_idx <= idx_d;
      gnt_vld <= |gnt_d;
    end
  end

endmodule

// File: doc/rr_arbiter.md
# rr_arbiter

Parametrised round-robin arbiter for N requesters, successor to the two-channel `req_0`/`req_1` → `gen_0`/`gen_1` FSM arbiter. It grants one requester at a time and holds the grant while that requester keeps its request asserted. Arbitration rotates fairly after each release. It sits between shared-resource clients (bus masters, memory ports) and the resource mux, and drives the mux select directly from `gnt_idx`.

## Interface
- `N_REQ`, 2: number of requesters, 2..16.
- `IDX_W`, `$clog2(N_REQ)`: width of grant index, derived (do not override).
- `MAX_HOLD`, 16: maximum consecutive grant cycles before forced handover (only with `RR_ARB_TIMEOUT_EN`), range 1..255.

- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset (0 = reset asserted).
- `req`  in  N_REQ  request vector, bit i = requester i.
- `gnt`  out  N_REQ  one-hot grant, registered; all-zero when idle.
- `gnt_idx`  out  IDX_W  binary index of current owner; 0 when idle.
- `gnt_vld`  out  1  high while any grant is active (= |gnt).

## Operation
- States: `IDLE` (no owner), `GRANT` (owner held in register).
- Priority pointer `ptr` (IDX_W bits) marks the highest-priority requester. The search order is ptr, ptr+1, …, N_REQ-1, 0, …, ptr-1 (wrap-around modulo N_REQ).
- IDLE: if any `req` bit is set, grant the first set bit in search order and go to GRANT. Otherwise stay.
- GRANT, owner still requesting: hold grant. Other requests are ignored (lock semantics).
- GRANT, owner drops `req`:
  - set `ptr` = owner+1 (mod N_REQ);
  - in the same edge, grant the next pending requester in the new search order (zero-bubble handover);
  - if none is pending, go to IDLE.
- An owner never loses the grant except by dropping `req`, by timeout (see Configuration), or by reset.
- Simultaneous requests are resolved by pointer order only; no requester is starved.
- Exactly one `gnt` bit may be high at any time. `gnt_idx` always matches `gnt`.
- Reset (`reset`=0 at an edge), from any state including mid-grant: `gnt`=0, `gnt_idx`=0, `gnt_vld`=0, `ptr`=0, state=IDLE, hold counter=0. Requests present during reset are ignored until the first edge with `reset`=1.

## Timing
- Grant latency is 1 cycle. A `req` sampled high at edge k (state IDLE) produces `gnt` high after edge k.
- Release latency is 1 cycle. `req[owner]` sampled low at edge k produces owner `gnt` low after edge k, with the next grant (if any) valid in the same cycle.
- No combinational path from `req` to any output. All outputs are registered.
- A requester that drops and re-raises `req` between edges is not seen; the design samples only at edges.

## Configuration
- Macro: `RR_ARB_TIMEOUT_EN`.
- Defined:
  - 8-bit hold counter, cleared on each new grant, incremented each cycle in GRANT, saturating at MAX_HOLD.
  - When count = MAX_HOLD and another requester is pending: force handover at that edge (ptr = owner+1, grant next pending), even though the owner still requests.
  - If no other requester is pending, the owner keeps the grant and the counter stays saturated.
- Undefined: no counter logic is present, `MAX_HOLD` is ignored, and hold is unbounded.

## Structure
- Shared package `rr_arb_pkg`:
  - state enum `RR_IDLE`/`RR_GRANT`;
  - `RR_CNT_W` = 8;
  - localparam limits for N_REQ (min 2, max 16).
- Sub-module `rr_pick`: combinational "first set bit at or after ptr" with wrap-around. Inputs are req vector and ptr; outputs are a one-hot vector, an index and a found flag. It is used for both IDLE grants and handovers.

## Test plan
- Reset: `reset`=0 for 2 cycles with `req`=4'b1111 (N_REQ=4) → `gnt`=0, `gnt_idx`=0, `gnt_vld`=0 throughout.
- Single request: `req`=4'b0100 after reset → `gnt`=4'b0100, `gnt_idx`=2 one cycle later. Hold `req` 5 cycles → grant held 5 cycles. Drop `req` → `gnt`=0 next cycle.
- Rotation: `req`=4'b1111 held. Each owner drops `req` for one cycle after 2 cycles of grant → grant order 0,1,2,3,0 with no idle cycle between grants.
- Lock: ch1 granted, then `req`=4'b1011 → `gnt` stays 4'b0010 until `req[1]` drops, then `gnt`=4'b0100 is not possible, so `gnt`=4'b1000 (next set bit after 1 is ch3).
- Timeout (`RR_ARB_TIMEOUT_EN`, MAX_HOLD=4): ch0 and ch2 both hold `req` → ch0 granted 4 cycles, then ch2 granted 4, then ch0. Repeat with ch0 alone → grant held indefinitely.
- Reset mid-grant: ch3 granted, `reset`=0 for 1 cycle with `req`=4'b1001 → outputs 0. After release, ch0 is granted (ptr restored to 0).
